sequence_checker: RTL
=====================

// Module: sequence_checker
// PURPOSE
//  Consumer end of the RNG interface in the memory-tester game: captures SEQ_LEN random digits
//  presented on rng_num/rng_enable, replays them to the display, then checks the player's entries.
//  Sits between the RNG and the display/score logic; gated by the authentication bit.
// PARAMETERS
//  DIGIT_W     4   width of one digit (matches RNG random_num)
//  SEQ_LEN     4   digits per round (2..15)
//  SHOW_CYCLES 8   clk cycles each stored digit stays on display_num during replay
// PORTS
//  clk          in   1        system clock, rising edge
//  rst          in   1        asynchronous, active-low reset
//  auth_bit     in   1        1 = player authenticated; 0 forces return to IDLE
//  rng_enable   in   1        one-cycle strobe: rng_num valid this cycle
//  rng_num      in   DIGIT_W  random digit from the RNG
//  enter_pulse  in   1        one-cycle strobe: player_num valid this cycle
//  player_num   in   DIGIT_W  digit entered by player
//  display_num  out  DIGIT_W  digit shown during replay, else 0
//  display_vld  out  1        1 while display_num carries a stored digit
//  entry_idx    out  4        index of next expected entry (0..SEQ_LEN-1)
//  pass         out  1        sticky: whole sequence matched
//  fail         out  1        sticky: a mismatch occurred
//  busy         out  1        1 in CAPTURE, SHOW, ENTRY
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; all outputs 0; capture/show/entry counters 0; memory 0.
//  - States: IDLE -> CAPTURE -> SHOW -> ENTRY -> PASS | FAIL.
//  - IDLE: outputs 0. auth_bit=1 -> CAPTURE next cycle.
//  - CAPTURE: each rng_enable=1 writes rng_num into mem[cap_cnt], cap_cnt++ (same edge).
//    Write of index SEQ_LEN-1 -> SHOW next cycle. enter_pulse ignored.
//  - SHOW: display_vld=1, display_num=mem[show_idx], registered outputs; first digit visible
//    the cycle after entering SHOW. Each digit held exactly SHOW_CYCLES cycles; after last
//    digit display_vld=0, display_num=0, -> ENTRY. rng_enable and enter_pulse ignored.
//  - ENTRY: on enter_pulse compare player_num to mem[entry_idx] (full DIGIT_W equality).
//    Match, idx<SEQ_LEN-1: entry_idx++. Match at SEQ_LEN-1: -> PASS. Mismatch: -> FAIL.
//    pass/fail assert the cycle after the deciding enter_pulse. rng_enable ignored.
//  - PASS/FAIL: flag held, busy=0; stay until auth_bit=0. No re-entry without auth drop.
//  - auth_bit=0 in any state: next edge -> IDLE, counters and flags cleared, memory kept.
//  - Simultaneous rng_enable and enter_pulse: only the one legal for current state acts.
//  - enter_pulse held >1 cycle counts once per high cycle (caller supplies clean pulses).
//  - Counters: cap_cnt/show_idx/entry_idx 4 bits, never exceed SEQ_LEN-1; hold timer
//    $clog2(SHOW_CYCLES) bits, no wrap beyond SHOW_CYCLES-1.
//  - Mid-operation reset: immediate return to reset values regardless of state.
// STRUCTURE
//  - Shared package/include: state encodings (S_IDLE..S_FAIL, 3 bits), DIGIT_W default.
//  - Sub-module seq_mem: SEQ_LEN x DIGIT_W register file, 1 write port, 2 async read ports
//    (show_idx, entry_idx), async active-low reset clears contents.
//  - Top: FSM + capture/show/entry counters + hold timer + registered outputs.
// TESTING
//  - Reset: rst=0 mid-SHOW -> all outputs 0 immediately; after release with auth_bit=0 stays IDLE.
//  - Capture/replay: auth=1, rng 3,7,1,9 on 4 strobes -> display_vld=1 for 32 cycles showing
//    3,7,1,9 for 8 cycles each, then display_vld=0, busy=1, entry_idx=0.
//  - Pass: enter 3,7,1,9 -> entry_idx 0,1,2,3 progression; pass=1 cycle after 4th pulse, busy=0.
//  - Fail: enter 3,8 -> fail=1 cycle after 2nd pulse, pass=0, entry_idx=1 held.
//  - Ignore rules: enter_pulse during CAPTURE/SHOW and rng_enable during ENTRY -> no state change.
//  - Auth drop: auth=0 during ENTRY after 2 matches -> IDLE, entry_idx=0; re-auth recaptures fresh digits.

Source files
------------

// File: rtl/sequence_checker_pkg.sv
// Shared types for the memory-tester sequence checker: FSM state encoding and default digit width.
package sequence_checker_pkg;

    localparam int DIGIT_W_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_SHOW    = 3'd2,
        S_ENTRY   = 3'd3,
        S_PASS    = 3'd4,
        S_FAIL    = 3'd5
    } state_e;

endpackage

// File: rtl/sequence_checker_if.sv
// Game-side signal bundle of the sequence checker: RNG strobe, player entry, display and score.
interface sequence_checker_if
    import sequence_checker_pkg::*;
#(
    parameter int DIGIT_W = DIGIT_W_DEF
);
    logic               auth_bit;
    logic               rng_enable;
    logic [DIGIT_W-1:0] rng_num;
    logic               enter_pulse;
    logic [DIGIT_W-1:0] player_num;
    logic [DIGIT_W-1:0] display_num;
    logic               display_vld;
    logic [3:0]         entry_idx;
    logic               pass;
    logic               fail;
    logic               busy;

    modport master (
        output auth_bit, rng_enable, rng_num, enter_pulse, player_num,
        input  display_num, display_vld, entry_idx, pass, fail, busy
    );

    modport slave (
        input  auth_bit, rng_enable, rng_num, enter_pulse, player_num,
        output display_num, display_vld, entry_idx, pass, fail, busy
    );
endinterface

// File: rtl/sequence_checker_seq_mem.sv
// Digit store for one round: single write port, two asynchronous read ports.
// Out-of-range read indices return 0 so callers may present a look-ahead index safely.
module seq_mem
    import sequence_checker_pkg::*;
#(
    parameter int DIGIT_W = DIGIT_W_DEF,
    parameter int SEQ_LEN = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en_i,
    input  logic [3:0]         wr_idx_i,
    input  logic [DIGIT_W-1:0] wr_data_i,
    input  logic [3:0]         rd_a_idx_i,
    output logic [DIGIT_W-1:0] rd_a_data_o,
    input  logic [3:0]         rd_b_idx_i,
    output logic [DIGIT_W-1:0] rd_b_data_o
);
    localparam int         AW      = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam logic [4:0] LEN_EXT = 5'(SEQ_LEN);

    logic [DIGIT_W-1:0] mem_q [SEQ_LEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SEQ_LEN; i++) mem_q[i] <= '0;
        end else if (wr_en_i && ({1'b0, wr_idx_i} < LEN_EXT)) begin
            mem_q[wr_idx_i[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_a_data_o = ({1'b0, rd_a_idx_i} < LEN_EXT) ? mem_q[rd_a_idx_i[AW-1:0]] : '0;
    assign rd_b_data_o = ({1'b0, rd_b_idx_i} < LEN_EXT) ? mem_q[rd_b_idx_i[AW-1:0]] : '0;

endmodule

// File: rtl/sequence_checker.sv
// Memory-tester consumer: captures SEQ_LEN RNG digits, replays them on the display,
// then scores the player's entries. Dropping auth_bit aborts to IDLE from anywhere.
//   state     | meaning
//   S_IDLE    | waiting for auth_bit, all outputs 0
//   S_CAPTURE | storing one digit per rng_enable strobe
//   S_SHOW    | replaying each stored digit for SHOW_CYCLES cycles
//   S_ENTRY   | comparing player entries against the stored digits
//   S_PASS    | whole sequence matched, waiting for auth drop
//   S_FAIL    | a mismatch occurred, waiting for auth drop
module sequence_checker
    import sequence_checker_pkg::*;
#(
    parameter int DIGIT_W     = DIGIT_W_DEF,
    parameter int SEQ_LEN     = 4,
    parameter int SHOW_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    sequence_checker_if.slave  bus
);
    localparam int               TMR_W    = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [3:0]       LAST_IDX = 4'(SEQ_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SHOW_CYCLES - 1);

    state_e             state_q;
    logic [3:0]         cap_cnt_q;
    logic [3:0]         show_idx_q;
    logic [3:0]         entry_idx_q;
    logic [TMR_W-1:0]   tmr_q;
    logic [DIGIT_W-1:0] display_num_q;
    logic               display_vld_q;
    logic               pass_q;
    logic               fail_q;
    logic               busy_q;

    logic               wr_en;
    logic               digit_done;
    logic [3:0]         show_rd_idx;
    logic [DIGIT_W-1:0] show_digit;
    logic [DIGIT_W-1:0] entry_digit;

    assign wr_en       = bus.auth_bit && (state_q == S_CAPTURE) && bus.rng_enable;
    assign digit_done  = display_vld_q && (tmr_q == '0);
    // Look one digit ahead on the expiring cycle so display_num stays a pure register load.
    assign show_rd_idx = digit_done ? show_idx_q + 4'd1 : show_idx_q;

    seq_mem #(
        .DIGIT_W (DIGIT_W),
        .SEQ_LEN (SEQ_LEN)
    ) u_seq_mem (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en_i     (wr_en),
        .wr_idx_i    (cap_cnt_q),
        .wr_data_i   (bus.rng_num),
        .rd_a_idx_i  (show_rd_idx),
        .rd_a_data_o (show_digit),
        .rd_b_idx_i  (entry_idx_q),
        .rd_b_data_o (entry_digit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cap_cnt_q     <= '0;
            show_idx_q    <= '0;
            entry_idx_q   <= '0;
            tmr_q         <= '0;
            display_num_q <= '0;
            display_vld_q <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else if (!bus.auth_bit) begin
            state_q       <= S_IDLE;
            cap_cnt_q     <= '0;
            show_idx_q    <= '0;
            entry_idx_q   <= '0;
            tmr_q         <= '0;
            display_num_q <= '0;
            display_vld_q <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_CAPTURE;
                    busy_q  <= 1'b1;
                end
                S_CAPTURE: begin
                    if (bus.rng_enable) begin
                        if (cap_cnt_q == LAST_IDX) begin
                            cap_cnt_q <= '0;
                            state_q   <= S_SHOW;
                        end else begin
                            cap_cnt_q <= cap_cnt_q + 4'd1;
                        end
                    end
                end
                S_SHOW: begin
                    if (!display_vld_q) begin
                        display_vld_q <= 1'b1;
                        display_num_q <= show_digit;
                        tmr_q         <= TMR_LOAD;
                    end else if (tmr_q != '0) begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end else if (show_idx_q == LAST_IDX) begin
                        display_vld_q <= 1'b0;
                        display_num_q <= '0;
                        show_idx_q    <= '0;
                        state_q       <= S_ENTRY;
                    end else begin
                        show_idx_q    <= show_idx_q + 4'd1;
                        display_num_q <= show_digit;
                        tmr_q         <= TMR_LOAD;
                    end
                end
                S_ENTRY: begin
                    if (bus.enter_pulse) begin
                        if (bus.player_num != entry_digit) begin
                            state_q <= S_FAIL;
                            fail_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (entry_idx_q == LAST_IDX) begin
                            state_q <= S_PASS;
                            pass_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            entry_idx_q <= entry_idx_q + 4'd1;
                        end
                    end
                end
                S_PASS, S_FAIL: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.display_num = display_num_q;
    assign bus.display_vld = display_vld_q;
    assign bus.entry_idx   = entry_idx_q;
    assign bus.pass        = pass_q;
    assign bus.fail        = fail_q;
    assign bus.busy        = busy_q;

endmodule
